mp_out_port: RTL and testbench

// - Consumer end of the MP output path: captures every 16-bit word the core writes to its output

---
 rtl/mp_pkg.sv | 7 +
 rtl/mp_sync_fifo.sv | 53 +++++
 rtl/mp_out_port.sv | 70 +++++++
 tb/tb_mp_out_port.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// mp_pkg: shared constants for the MP output path.
//   MP_DATA_W        - datapath word width
//   MP_OUT_PORT_ADDR - I/O address the decoder matches to raise the port write enable
package mp_pkg;
    localparam int         MP_DATA_W        = 16;
    localparam logic [7:0] MP_OUT_PORT_ADDR = 8'h01;
endpackage

// File: rtl/mp_sync_fifo.sv
// mp_sync_fifo: single-clock FIFO holding storage, pointers and occupancy.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_push, i_data - store i_data at the write pointer (caller guarantees not full)
//   i_pop          - advance the read pointer (caller guarantees not empty)
//   o_head         - storage[rd_ptr], unqualified
//   o_count        - occupancy, 0..DEPTH
module mp_sync_fifo
    import mp_pkg::*;
#(
    parameter  int DATA_W = MP_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mp_out_port.sv
// mp_out_port: consumer end of the MP output path. Buffers core OUT writes and
// hands them to an external reader over valid/ready.
//   i_clk, i_rst_n         - clock, async active-low reset
//   i_wr_en, i_wr_data     - core write strobe and word
//   o_full                 - DEPTH words buffered; core must stall
//   o_rd_valid, o_rd_data  - head-of-FIFO word (0 when empty)
//   i_rd_ready             - reader accepts o_rd_data this cycle
//   o_design_out           - last word accepted from the core
//   o_count                - occupancy
//   o_overflow             - sticky; write attempted while full
module mp_out_port
    import mp_pkg::*;
#(
    parameter  int DATA_W = MP_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_full,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [DATA_W-1:0] o_design_out,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow
);

    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] r_design_out;
    logic              r_overflow;

    // Flags come only from the registered count, so i_rd_ready never reaches o_full.
    // A write while full is rejected even if the same cycle pops.
    assign o_full     = (w_count == CNT_W'(DEPTH));
    assign o_rd_valid = (w_count != '0);
    assign w_push     = i_wr_en && !o_full;
    assign w_pop      = o_rd_valid && i_rd_ready;

    mp_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (i_wr_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_design_out <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) r_design_out <= i_wr_data;
            if (i_wr_en && o_full) r_overflow <= 1'b1;
        end
    end

    assign o_rd_data    = o_rd_valid ? w_head : '0;
    assign o_design_out = r_design_out;
    assign o_count      = w_count;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_mp_out_port.sv
module tb_mp_out_port;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_ready = 1'b0;
    logic        full;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] design_out;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a queue of buffered words plus the mirror and sticky flag.
    logic [15:0] mq[$];
    logic [15:0] m_dout = '0;
    logic        m_ovf = 1'b0;

    always #5 clk = ~clk;

    mp_out_port #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_data    (wr_data),
        .o_full       (full),
        .o_rd_valid   (rd_valid),
        .i_rd_ready   (rd_ready),
        .o_rd_data    (rd_data),
        .o_design_out (design_out),
        .o_count      (count),
        .o_overflow   (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
        chk("m_valid", 32'(rd_valid), 32'(mq.size() != 0));
        chk("m_rd_data", 32'(rd_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("m_dout", 32'(design_out), 32'(m_dout));
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
    end

    // One clock of stimulus; called just after a falling edge.
    task automatic step(input logic wr, input logic [15:0] d, input logic rdy);
        bit was_full;
        bit do_pop;
        wr_en = wr; wr_data = d; rd_ready = rdy;
        @(posedge clk);
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && rdy;
        if (wr && was_full) m_ovf = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (wr && !was_full) begin
            mq.push_back(d);
            m_dout = d;
        end
        @(negedge clk);
        wr_en = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(rd_valid), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_dout"}, 32'(design_out), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        mq.delete(); m_dout = '0; m_ovf = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rel_count", 32'(count), 0);
    endtask

    initial begin
        @(negedge clk);
        chk_all_zero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Single word
        step(1'b1, 16'hBEEF, 1'b0);
        chk("single_dout", 32'(design_out), 32'h0000BEEF);
        chk("single_valid", 32'(rd_valid), 1);
        chk("single_data", 32'(rd_data), 32'h0000BEEF);
        step(1'b0, 16'h0, 1'b1);
        chk("single_popped", 32'(rd_valid), 0);

        // Fill and overflow
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
        step(1'b1, 16'h0005, 1'b0);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_dout", 32'(design_out), 4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            step(1'b0, 16'h0, 1'b1);
        end
        chk("drain_empty", 32'(rd_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Reset mid-stream with words buffered
        step(1'b1, 16'h0A0A, 1'b0);
        step(1'b1, 16'h0B0B, 1'b0);
        mid_reset();

        // Streaming
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 1'b1);
            chk("stream_count", 32'(count), 1);
            chk("stream_full", 32'(full), 0);
            chk("stream_data", 32'(rd_data), 32'h100 + 32'(i));
        end
        step(1'b0, 16'h0, 1'b1);
        chk("stream_empty", 32'(rd_valid), 0);

        // Wrap with random gaps
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 16'h0200 + 16'(k), 1'b0);
            repeat ($urandom_range(0, 2)) step(1'b0, 16'h0, 1'b0);
            chk("wrap_data", 32'(rd_data), 32'h200 + 32'(k));
            step(1'b0, 16'h0, 1'b1);
        end
        chk("wrap_ovf", 32'(overflow), 0);
        chk("wrap_empty", 32'(rd_valid), 0);

        // Full with simultaneous read: write rejected, read proceeds
        for (int i = 1; i <= 4; i++) step(1'b1, 16'h0010 + 16'(i), 1'b0);
        step(1'b1, 16'hDEAD, 1'b1);
        chk("fsim_count", 32'(count), 3);
        chk("fsim_ovf", 32'(overflow), 1);
        chk("fsim_dout", 32'(design_out), 32'h14);
        for (int i = 2; i <= 4; i++) begin
            chk("fsim_drain", 32'(rd_data), 32'h10 + 32'(i));
            step(1'b0, 16'h0, 1'b1);
        end
        chk("fsim_empty", 32'(rd_valid), 0);

        // Rd_ready while empty is ignored
        step(1'b0, 16'h0, 1'b1);
        chk("empty_ready_count", 32'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
